// File: rtl/tron_pkg.sv
// Shared TRON game types: heading encodings, tracker state, and edge-handling modes.
package tron_pkg;

  localparam logic [1:0] DIR_YP = 2'b00;
  localparam logic [1:0] DIR_XP = 2'b01;
  localparam logic [1:0] DIR_YM = 2'b10;
  localparam logic [1:0] DIR_XM = 2'b11;

  localparam int EDGE_WRAP = 0;
  localparam int EDGE_STOP = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CRASHED = 2'd2
  } state_t;

  // A heading is reversed by flipping the axis-sign bit.
  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One coordinate axis: computes the next cell for a +1/-1 move, wrapping or flagging the edge.
module axis_stepper
  import tron_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX       = 159,
  parameter int EDGE_MODE = EDGE_STOP
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt,
  output logic         out_of_range
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    nxt          = cur;
    out_of_range = 1'b0;
    if (inc) begin
      if (cur == MAX_V) begin
        if (EDGE_MODE == EDGE_STOP) out_of_range = 1'b1;
        else                        nxt = '0;
      end else begin
        nxt = cur + 1'b1;
      end
    end else if (dec) begin
      if (cur == '0) begin
        if (EDGE_MODE == EDGE_STOP) out_of_range = 1'b1;
        else                        nxt = MAX_V;
      end else begin
        nxt = cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_position_tracker.sv
// TRON player head register: heading, (x,y) stepping per tick, reversal filter, crash latch.
// Define TRACKER_TRAIL_OUT_EN to add trail_we/trail_x/trail_y carrying the vacated cell.
module player_position_tracker
  import tron_pkg::*;
#(
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119,
  parameter int         X_INIT    = 40,
  parameter int         Y_INIT    = 60,
  parameter logic [1:0] DIR_INIT  = 2'b01,
  parameter int         EDGE_MODE = EDGE_STOP
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  input  logic           step_en,
  input  logic           dir_valid,
  input  logic [1:0]     dir_in,
  input  logic           hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     dir,
  output logic           moved,
  output logic           crashed,
  output logic           running
`ifdef TRACKER_TRAIL_OUT_EN
  ,
  output logic           trail_we,
  output logic [X_W-1:0] trail_x,
  output logic [Y_W-1:0] trail_y
`endif
);

  state_t         state;
  logic [1:0]     pending;
  logic           accept;
  logic [1:0]     eff;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           x_oor;
  logic           y_oor;

  // Reversal check is against the committed heading, so two quick turns can't sneak a U-turn.
  assign accept = dir_valid && (state != CRASHED) && (dir_in != reverse_of(dir));
  assign eff    = accept ? dir_in : pending;

  axis_stepper #(.W(X_W), .MAX(X_MAX), .EDGE_MODE(EDGE_MODE)) u_x_axis (
    .cur          (x),
    .inc          (eff == DIR_XP),
    .dec          (eff == DIR_XM),
    .nxt          (x_nxt),
    .out_of_range (x_oor)
  );

  axis_stepper #(.W(Y_W), .MAX(Y_MAX), .EDGE_MODE(EDGE_MODE)) u_y_axis (
    .cur          (y),
    .inc          (eff == DIR_YP),
    .dec          (eff == DIR_YM),
    .nxt          (y_nxt),
    .out_of_range (y_oor)
  );

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      x        <= X_W'(X_INIT);
      y        <= Y_W'(Y_INIT);
      dir      <= DIR_INIT;
      pending  <= DIR_INIT;
      moved    <= 1'b0;
      crashed  <= 1'b0;
      running  <= 1'b0;
`ifdef TRACKER_TRAIL_OUT_EN
      trail_we <= 1'b0;
      trail_x  <= '0;
      trail_y  <= '0;
`endif
    end else begin
      moved <= 1'b0;
`ifdef TRACKER_TRAIL_OUT_EN
      trail_we <= 1'b0;
`endif
      if (accept) pending <= dir_in;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // A hit in the same tick beats the move.
          if (hit || (step_en && (x_oor || y_oor))) begin
            state   <= CRASHED;
            crashed <= 1'b1;
            running <= 1'b0;
          end else if (step_en) begin
            x     <= x_nxt;
            y     <= y_nxt;
            dir   <= eff;
            moved <= 1'b1;
`ifdef TRACKER_TRAIL_OUT_EN
            trail_we <= 1'b1;
            trail_x  <= x;
            trail_y  <= y;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_position_tracker.sv
// Scoreboard bench: wrap-mode and crash-mode trackers share stimulus, each against its own model.
module tb_player_position_tracker;

  localparam int XM = 159;
  localparam int YM = 119;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] dir;
    logic       moved;
    logic       crashed;
    logic       running;
  } obs_t;

  logic       CLOCK_50;
  logic       reset, start, step_en, dir_valid, hit;
  logic [1:0] dir_in;

  logic [7:0] x_w, x_s;
  logic [6:0] y_w, y_s;
  logic [1:0] dir_w, dir_s;
  logic       moved_w, moved_s, crashed_w, crashed_s, running_w, running_s;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t q_wrap[$];
  obs_t q_stop[$];

  // Reference state per DUT (0 = wrap, 1 = crash at edge); mode 0 idle, 1 running, 2 crashed.
  int m_x[2], m_y[2], m_dir[2], m_pend[2], m_mode[2];
  bit m_moved[2];

  player_position_tracker #(.EDGE_MODE(0)) dut_wrap (
    .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .step_en (step_en),
    .dir_valid (dir_valid), .dir_in (dir_in), .hit (hit),
    .x (x_w), .y (y_w), .dir (dir_w), .moved (moved_w), .crashed (crashed_w), .running (running_w)
  );

  player_position_tracker #(.EDGE_MODE(1)) dut_stop (
    .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .step_en (step_en),
    .dir_valid (dir_valid), .dir_in (dir_in), .hit (hit),
    .x (x_s), .y (y_s), .dir (dir_s), .moved (moved_s), .crashed (crashed_s), .running (running_s)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d dir=%0d moved=%b crashed=%b running=%b, want x=%0d y=%0d dir=%0d moved=%b crashed=%b running=%b",
               name, $time, act.x, act.y, act.dir, act.moved, act.crashed, act.running,
               exp.x, exp.y, exp.dir, exp.moved, exp.crashed, exp.running);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_tick(input int m, input bit r, s, st, dv, input int di, input bit h);
    bit accept;
    int eff, nx, ny;
    if (r) begin
      m_x[m] = 40; m_y[m] = 60; m_dir[m] = 1; m_pend[m] = 1;
      m_mode[m] = 0; m_moved[m] = 0;
      return;
    end
    m_moved[m] = 0;
    accept = dv && m_mode[m] != 2 && di != (m_dir[m] + 2) % 4;
    eff = accept ? di : m_pend[m];
    if (accept) m_pend[m] = di;
    if (m_mode[m] == 0) begin
      if (s) m_mode[m] = 1;
    end else if (m_mode[m] == 1) begin
      if (h) m_mode[m] = 2;
      else if (st) begin
        nx = m_x[m] + ((eff == 1) ? 1 : (eff == 3) ? -1 : 0);
        ny = m_y[m] + ((eff == 0) ? 1 : (eff == 2) ? -1 : 0);
        if ((nx < 0 || nx > XM || ny < 0 || ny > YM) && m == 1) begin
          m_mode[m] = 2;
        end else begin
          m_x[m] = (nx + XM + 1) % (XM + 1);
          m_y[m] = (ny + YM + 1) % (YM + 1);
          m_dir[m] = eff;
          m_moved[m] = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, s, st, dv, input logic [1:0] di, input bit h);
    obs_t e;
    @(negedge CLOCK_50);
    reset = r; start = s; step_en = st; dir_valid = dv; dir_in = di; hit = h;
    for (int m = 0; m < 2; m++) begin
      model_tick(m, r, s, st, dv, int'(di), h);
      e.x       = 8'(m_x[m]);
      e.y       = 7'(m_y[m]);
      e.dir     = 2'(m_dir[m]);
      e.moved   = m_moved[m];
      e.crashed = (m_mode[m] == 2);
      e.running = (m_mode[m] == 1);
      if (m == 0) q_wrap.push_back(e);
      else        q_stop.push_back(e);
    end
  endtask

  task automatic steps(input int n, input bit dv, input logic [1:0] di);
    for (int i = 0; i < n; i++) drive(0, 0, 1, dv, di, 0);
  endtask

  task automatic restart();
    drive(1, 0, 0, 0, 2'b00, 0);
    drive(0, 1, 0, 0, 2'b00, 0);
  endtask

  // Monitor: compares each DUT against the oldest outstanding expectation just after each edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (q_wrap.size() > 0) begin
        e = q_wrap.pop_front();
        check("wrap_dut", {x_w, y_w, dir_w, moved_w, crashed_w, running_w}, e);
      end
      if (q_stop.size() > 0) begin
        e = q_stop.pop_front();
        check("stop_dut", {x_s, y_s, dir_s, moved_s, crashed_s, running_s}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; step_en = 1'b0; dir_valid = 1'b0; dir_in = 2'b00; hit = 1'b0;

    // Reset state, then start and three +x ticks from (40,60).
    drive(1, 0, 0, 0, 2'b00, 0);
    drive(1, 0, 1, 1, 2'b10, 1);
    drive(0, 1, 0, 1, 2'b01, 0);
    steps(3, 0, 2'b00);
    drive(0, 0, 0, 0, 2'b00, 0);

    // Reversal request is dropped; the step continues +x.
    restart();
    drive(0, 0, 0, 1, 2'b11, 0);
    steps(1, 0, 2'b00);
    // Same-cycle reversal with the step is also dropped.
    drive(0, 0, 1, 1, 2'b11, 0);

    // Drive to x=159 then step off the right edge; turn via +y, then -x across x=0.
    restart();
    steps(119, 0, 2'b00);
    steps(1, 0, 2'b00);
    steps(1, 1, 2'b00);
    steps(1, 1, 2'b11);
    steps(2, 0, 2'b00);

    // Drive to y=119 heading +y then off the top edge; further steps ignored in crash mode.
    restart();
    drive(0, 0, 0, 1, 2'b00, 0);
    steps(59, 0, 2'b00);
    steps(3, 0, 2'b00);
    drive(0, 1, 1, 1, 2'b01, 1);

    // Hit with step at (50,60): crash wins, no move.
    restart();
    steps(10, 0, 2'b00);
    drive(0, 0, 1, 0, 2'b00, 1);
    drive(0, 0, 1, 0, 2'b00, 0);

    // Reset mid-run with step and heading request active.
    restart();
    steps(5, 1, 2'b00);
    drive(1, 0, 1, 1, 2'b00, 0);
    drive(0, 0, 1, 0, 2'b00, 0);

    // Randomised play.
    restart();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 149) == 0);
    end

    drive(0, 0, 0, 0, 2'b00, 0);
    @(posedge CLOCK_50);
    #3;
    check_int("wrap_queue_drained", q_wrap.size(), 0);
    check_int("stop_queue_drained", q_stop.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
